// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, fetch defaults and the fetch FSM encoding.
// Imported by the fetch stage and by the decode/control unit.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register and one-entry skid buffer.
// One outstanding imem request; responses belonging to a redirected path are dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::INSTR_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [6:0]  if_opcode_o
);
    import riscv_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_pc_q, skid_instr_q;
    logic         skid_load;
    logic         ifv_q, ifv_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  redirect_target;
    logic         unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_load    = 1'b0;
        ifv_d        = ifv_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        // Decode takes the held instruction; any load below overrides the bubble.
        if (ifv_q && !stall_i) begin
            ifv_d = 1'b0;
        end

        if (redirect_i) begin
            pc_d         = redirect_target;
            ifv_d        = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!ifv_q || !stall_i) begin
                            ifv_d      = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata_i;
                            pc_d       = pc_q + 32'd4;
                            state_d    = S_REQ;
                        end else begin
                            skid_load    = 1'b1;
                            skid_valid_d = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i && skid_valid_q) begin
                        ifv_d        = 1'b1;
                        if_pc_d      = skid_pc_q;
                        if_instr_d   = skid_instr_q;
                        skid_valid_d = 1'b0;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            ifv_q        <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            ifv_q        <= ifv_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    // Skid payload is qualified by skid_valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (skid_load) begin
            skid_pc_q    <= pc_q;
            skid_instr_q <= imem_rdata_i;
        end
    end

    assign imem_req_o  = (state_q == S_REQ) && !rst_i;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = ifv_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = ifv_q ? if_instr_q : NOP_INSTR;
    assign if_opcode_o = if_instr_o[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against an in-order fetch-stream model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [6:0]  if_opcode_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .if_opcode_o(if_opcode_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory model state
    int          gnt_rate = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          pending  = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = 32'h0;
    bit          stray    = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0020_8133;
        return {a[26:2], 7'h33};
    endfunction

    // Drives the memory side for the next rising edge, then advances to just after it.
    task automatic step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (stray) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
            stray         = 1'b0;
        end else if (pending) begin
            if (cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(paddr);
                pending       = 1'b0;
            end else begin
                cnt--;
            end
        end else if (imem_req_o && (int'($urandom_range(99)) < gnt_rate)) begin
            imem_gnt_i = 1'b1;
            paddr      = imem_addr_o;
            pending    = 1'b1;
            cnt        = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o, if_opcode_o, imem_req_o} !== {1'b0, 32'h0, NOP, 7'h13, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b pc=%h instr=%h op=%h req=%b, expected v=0 pc=0 instr=%h op=13 req=0",
                     if_valid_o, if_pc_o, if_instr_o, if_opcode_o, imem_req_o, NOP);
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release_req: got req=%b addr=%h, expected req=1 addr=00000000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_basic();
        logic [31:0] a;
        logic [31:0] w;
        for (int k = 0; k < 6; k++) begin
            a = 32'(4 * k);
            w = mem_word(a);
            n_checks++;
            if ({imem_req_o, imem_addr_o} !== {1'b1, a}) begin
                n_fail++;
                $display("FAIL basic_req k=%0d: got req=%b addr=%h, expected req=1 addr=%h", k, imem_req_o, imem_addr_o, a);
            end
            step();
            n_checks++;
            if ({imem_req_o, if_valid_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_wait k=%0d: got req=%b valid=%b, expected 0 0", k, imem_req_o, if_valid_o);
            end
            step();
            n_checks++;
            if ({if_valid_o, if_pc_o, if_instr_o, if_opcode_o} !== {1'b1, a, w, w[6:0]}) begin
                n_fail++;
                $display("FAIL basic_deliver k=%0d: got v=%b pc=%h instr=%h op=%h, expected v=1 pc=%h instr=%h op=%h",
                         k, if_valid_o, if_pc_o, if_instr_o, if_opcode_o, a, w, w[6:0]);
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({imem_req_o, if_valid_o, if_pc_o, if_instr_o} !== {1'b0, 1'b1, 32'd20, mem_word(32'd20)}) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d: got req=%b v=%b pc=%h instr=%h, expected req=0 v=1 pc=00000014 instr=%h",
                         i, imem_req_o, if_valid_o, if_pc_o, if_instr_o, mem_word(32'd20));
            end
        end
        stall_i = 1'b0;
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o, imem_req_o, imem_addr_o} !== {1'b1, 32'd24, mem_word(32'd24), 1'b1, 32'd28}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b pc=%h instr=%h req=%b addr=%h, expected v=1 pc=00000018 instr=%h req=1 addr=0000001c",
                     if_valid_o, if_pc_o, if_instr_o, imem_req_o, imem_addr_o, mem_word(32'd24));
        end
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'd28, mem_word(32'd28)}) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b pc=%h instr=%h, expected v=1 pc=0000001c", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({if_valid_o, imem_req_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL redir_wait_idle i=%0d: got v=%b req=%b, expected 0 0", i, if_valid_o, imem_req_o);
            end
            step();
        end
        n_checks++;
        if ({if_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL redir_wait_drop: got v=%b req=%b addr=%h, expected v=0 req=1 addr=00000100", if_valid_o, imem_req_o, imem_addr_o);
        end
        lat_min = 1; lat_max = 1;
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_fail++;
            $display("FAIL redir_wait_target: got v=%b pc=%h instr=%h, expected v=1 pc=00000100", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_redirect_rvalid_gnt();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if ({if_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL redir_rvalid: got v=%b req=%b addr=%h, expected v=0 req=1 addr=00000200", if_valid_o, imem_req_o, imem_addr_o);
        end
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            n_fail++;
            $display("FAIL redir_rvalid_target: got v=%b pc=%h instr=%h, expected v=1 pc=00000200", if_valid_o, if_pc_o, if_instr_o);
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        step();
        n_checks++;
        if ({if_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL redir_gnt: got v=%b req=%b addr=%h, expected v=0 req=1 addr=00000300", if_valid_o, imem_req_o, imem_addr_o);
        end
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h300, mem_word(32'h300)}) begin
            n_fail++;
            $display("FAIL redir_gnt_target: got v=%b pc=%h instr=%h, expected v=1 pc=00000300", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_align_wrap();
        gnt_rate = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        n_checks++;
        if ({if_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL redir_align: got v=%b req=%b addr=%h, expected v=0 req=1 addr=00000100", if_valid_o, imem_req_o, imem_addr_o);
        end
        gnt_rate = 100;
        step();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        n_checks++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_req: got req=%b addr=%h, expected req=1 addr=fffffffc", imem_req_o, imem_addr_o);
        end
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o, imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_next: got v=%b pc=%h instr=%h req=%b addr=%h, expected v=1 pc=fffffffc req=1 addr=00000000",
                     if_valid_o, if_pc_o, if_instr_o, imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_midflight();
        lat_min = 3; lat_max = 3;
        step();
        rst_i = 1'b1;
        #1;
        pending = 1'b0;
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o, imem_req_o} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got v=%b pc=%h instr=%h req=%b, expected v=0 pc=0 instr=%h req=0",
                     if_valid_o, if_pc_o, if_instr_o, imem_req_o, NOP);
        end
        step();
        step();
        rst_i = 1'b0;
        #1;
        stray = 1'b1;
        lat_min = 1; lat_max = 1;
        step();
        n_checks++;
        if ({if_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_stray: got v=%b req=%b addr=%h, expected v=0 req=1 addr=00000000", if_valid_o, imem_req_o, imem_addr_o);
        end
        step();
        step();
        n_checks++;
        if ({if_valid_o, if_pc_o, if_instr_o} !== {1'b1, 32'h0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL rst_mid_first: got v=%b pc=%h instr=%h, expected v=1 pc=00000000 instr=00000013", if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    // Model: decode must see an unbroken PC stream, restarting at each aligned redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] w;
        bit          st;
        bit          rd;
        int          consumed;
        exp_pc   = 32'h0;
        consumed = 0;
        gnt_rate = 70; lat_min = 1; lat_max = 3;
        for (int c = 0; c < 800; c++) begin
            st  = int'($urandom_range(99)) < 30;
            rd  = (c == 0) || (int'($urandom_range(99)) < 4);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom_range(4095));
            stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
            if (!if_valid_o) begin
                n_checks++;
                if (if_instr_o !== NOP) begin
                    n_fail++;
                    $display("FAIL rand_bubble c=%0d: got instr=%h, expected %h", c, if_instr_o, NOP);
                end
            end
            if (imem_req_o) begin
                n_checks++;
                if (imem_addr_o[1:0] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rand_align c=%0d: got addr=%h, expected low bits 00", c, imem_addr_o);
                end
            end
            if (if_valid_o && !st && !rd) begin
                w = mem_word(exp_pc);
                n_checks++;
                if ({if_pc_o, if_instr_o, if_opcode_o} !== {exp_pc, w, w[6:0]}) begin
                    n_fail++;
                    $display("FAIL rand_stream c=%0d: got pc=%h instr=%h op=%h, expected pc=%h instr=%h op=%h",
                             c, if_pc_o, if_instr_o, if_opcode_o, exp_pc, w, w[6:0]);
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rd) exp_pc = {tgt[31:2], 2'b00};
            step();
        end
        stall_i = 1'b0; redirect_i = 1'b0;
        n_checks++;
        if (consumed < 40) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d instructions consumed, expected at least 40", consumed);
        end
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_gnt();
        test_align_wrap();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
